// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   state_t    - sequencer FSM states
//   npc_src_t  - which source produced the next-PC candidate
//   XLEN, INSTR_BYTES, ALIGN_BITS - address width and instruction granule
//   align_down - clears the sub-instruction address bits
package pc_seq_pkg;

    localparam int XLEN        = 64;
    localparam int INSTR_BYTES = 4;
    localparam int ALIGN_BITS  = $clog2(INSTR_BYTES);

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_EXEC
    } state_t;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BRANCH,
        NPC_JUMP,
        NPC_TRAP
    } npc_src_t;

    function automatic logic [XLEN-1:0] align_down(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the PC register port, the instruction-memory fetch
// handshake, the core execute handshake and the redirect/trap inputs.
//   master - the sequencer side (drives pc_out/pc_we/imem_*/instr_valid/...)
//   slave  - the environment side (PC register, imem, core, trap source)
//
// Handshake semantics: imem_req acts as a valid and imem_ready as its ready.
// Once imem_req rises, imem_req and imem_addr stay stable until the cycle in
// which imem_ready is high; that cycle completes the transfer. Only reset may
// withdraw a pending request. instr_valid is a single-cycle hand-off to the
// core, and exec_done (with the redirect inputs) is accepted only while the
// sequencer is executing.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] pc_out;
    logic            pc_we;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            instr_valid;
    logic            exec_done;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            trap;
    logic [XLEN-1:0] trap_vector;
    logic            misalign;
    logic [63:0]     instret;

    modport master (
        input  pc_in, imem_ready, exec_done, branch_taken, branch_target,
               jump, jump_target, trap, trap_vector,
        output pc_out, pc_we, imem_req, imem_addr, instr_valid, misalign,
               instret
    );

    modport slave (
        output pc_in, imem_ready, exec_done, branch_taken, branch_target,
               jump, jump_target, trap, trap_vector,
        input  pc_out, pc_we, imem_req, imem_addr, instr_valid, misalign,
               instret
    );

endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux with alignment check.
//   Priority: trap > jump > branch > sequential (pc_in + INSTR_BYTES).
//   target   - selected next PC (trap vector already aligned down)
//   src      - which source won
//   misalign - selected jump/branch target has nonzero low bits
module pc_next_sel
    import pc_seq_pkg::*;
(
    input  logic [XLEN-1:0] pc_in,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] target,
    output npc_src_t        src,
    output logic            misalign
);

    always_comb begin
        // Sequential add wraps naturally modulo 2^XLEN.
        target   = pc_in + XLEN'(INSTR_BYTES);
        src      = NPC_SEQ;
        misalign = 1'b0;
        if (trap) begin
            target = align_down(trap_vector);
            src    = NPC_TRAP;
        end else if (jump) begin
            target   = jump_target;
            src      = NPC_JUMP;
            misalign = |jump_target[ALIGN_BITS-1:0];
        end else if (branch_taken) begin
            target   = branch_target;
            src      = NPC_BRANCH;
            misalign = |branch_target[ALIGN_BITS-1:0];
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/advance controller for the 64-bit program counter.
//   clk, reset  - clock; synchronous active-high reset
//   bus         - pc_sequencer_if.master (PC register port, imem handshake,
//                 core handshake, redirects, misalign flag, instret)
//   dbg_state   - current FSM state
//   dbg_npc_src - source chosen by the next-PC mux this cycle
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    pc_sequencer_if.master        bus,
    output state_t                dbg_state,
    output npc_src_t              dbg_npc_src
);

    state_t          state, state_next;
    logic            trap_pend;
    logic [XLEN-1:0] trap_vec_q;
    logic [63:0]     instret_q;

    logic [XLEN-1:0] sel_target;
    logic            sel_misalign;
    logic [XLEN-1:0] trap_target;

    logic            pc_we_c, imem_req_c, instr_valid_c, misalign_c;
    logic [XLEN-1:0] pc_out_c, imem_addr_c;
    logic            pend_set, pend_clr, retire;

    assign trap_target = align_down(bus.trap_vector);

    pc_next_sel u_next_sel (
        .pc_in         (bus.pc_in),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .trap          (bus.trap),
        .trap_vector   (bus.trap_vector),
        .target        (sel_target),
        .src           (dbg_npc_src),
        .misalign      (sel_misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RESET;
            trap_pend  <= 1'b0;
            trap_vec_q <= '0;
            instret_q  <= '0;
        end else begin
            state <= state_next;
            if (pend_clr) begin
                trap_pend <= 1'b0;
            end else if (pend_set) begin
                trap_pend  <= 1'b1;
                trap_vec_q <= trap_target;
            end
            if (retire) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        pc_we_c       = 1'b0;
        pc_out_c      = '0;
        imem_req_c    = 1'b0;
        imem_addr_c   = '0;
        instr_valid_c = 1'b0;
        misalign_c    = 1'b0;
        pend_set      = 1'b0;
        pend_clr      = 1'b0;
        retire        = 1'b0;

        case (state)
            S_RESET: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req_c  = 1'b1;
                imem_addr_c = bus.pc_in;
                if (bus.imem_ready) begin
                    if (trap_pend || bus.trap) begin
                        // Fetch completes but the instruction is dropped;
                        // a trap arriving on the ready cycle is the newest.
                        pc_we_c  = 1'b1;
                        pc_out_c = bus.trap ? trap_target : trap_vec_q;
                        pend_clr = 1'b1;
                    end else begin
                        instr_valid_c = 1'b1;
                        state_next    = S_EXEC;
                    end
                end else if (bus.trap) begin
                    pend_set = 1'b1;
                end
            end
            S_EXEC: begin
                if (bus.trap) begin
                    pc_we_c    = 1'b1;
                    pc_out_c   = trap_target;
                    state_next = S_FETCH;
                end else if (bus.exec_done) begin
                    pc_we_c    = 1'b1;
                    state_next = S_FETCH;
                    if (sel_misalign) begin
                        misalign_c = 1'b1;
                        pc_out_c   = trap_target;
                    end else begin
                        pc_out_c = sel_target;
                        retire   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_RESET;
            end
        endcase

        // Reset forces every externally visible strobe and value to zero
        // in the same cycle, abandoning any outstanding fetch.
        if (reset) begin
            state_next    = S_RESET;
            pc_we_c       = 1'b0;
            pc_out_c      = '0;
            imem_req_c    = 1'b0;
            imem_addr_c   = '0;
            instr_valid_c = 1'b0;
            misalign_c    = 1'b0;
            pend_set      = 1'b0;
            pend_clr      = 1'b0;
            retire        = 1'b0;
        end
    end

    assign bus.pc_we       = pc_we_c;
    assign bus.pc_out      = pc_out_c;
    assign bus.imem_req    = imem_req_c;
    assign bus.imem_addr   = imem_addr_c;
    assign bus.instr_valid = instr_valid_c;
    assign bus.misalign    = misalign_c;
    assign bus.instret     = reset ? 64'd0 : instret_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test of pc_sequencer. The bench plays the PC
// register, instruction memory and core; pc_in is updated by hand to the
// value the PC register would hold after each pc_we cycle.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic     clk;
    logic     reset;
    state_t   dbg_state;
    npc_src_t dbg_npc_src;
    int       checks;
    int       errors;

    pc_sequencer_if sif ();

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (sif),
        .dbg_state   (dbg_state),
        .dbg_npc_src (dbg_npc_src)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        sif.exec_done     = 1'b0;
        sif.branch_taken  = 1'b0;
        sif.branch_target = '0;
        sif.jump          = 1'b0;
        sif.jump_target   = '0;
        sif.trap          = 1'b0;
    endtask

    // Two-cycle fetch: request cycle with ready low, then ready high.
    task automatic do_fetch(input logic [63:0] addr);
        sif.imem_ready = 1'b0;
        #1;
        chk("fetch_req", 64'(sif.imem_req), 64'd1);
        chk("fetch_addr", sif.imem_addr, addr);
        chk("fetch_idle_we", 64'(sif.pc_we), 64'd0);
        chk("fetch_idle_pc_out", sif.pc_out, 64'd0);
        step();
        sif.imem_ready = 1'b1;
        #1;
        chk("fetch_instr_valid", 64'(sif.instr_valid), 64'd1);
        chk("fetch_ready_we", 64'(sif.pc_we), 64'd0);
        step();
        sif.imem_ready = 1'b0;
    endtask

    // One exec_done cycle with the given redirect inputs.
    task automatic do_exec(input logic br, input logic [63:0] bt,
                           input logic j, input logic [63:0] jt,
                           input logic tr, input logic [63:0] tv,
                           input logic [63:0] exp_pc, input logic exp_mis);
        sif.exec_done     = 1'b1;
        sif.branch_taken  = br;
        sif.branch_target = bt;
        sif.jump          = j;
        sif.jump_target   = jt;
        sif.trap          = tr;
        sif.trap_vector   = tv;
        #1;
        chk("exec_no_req", 64'(sif.imem_req), 64'd0);
        chk("exec_we", 64'(sif.pc_we), 64'd1);
        chk("exec_pc_out", sif.pc_out, exp_pc);
        chk("exec_misalign", 64'(sif.misalign), 64'(exp_mis));
        step();
        clear_redirects();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        sif.pc_in       = '0;
        sif.imem_ready  = 1'b0;
        sif.trap_vector = '0;
        clear_redirects();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_we", 64'(sif.pc_we), 64'd0);
        chk("rst_imem_req", 64'(sif.imem_req), 64'd0);
        chk("rst_imem_addr", sif.imem_addr, 64'd0);
        chk("rst_instr_valid", 64'(sif.instr_valid), 64'd0);
        chk("rst_misalign", 64'(sif.misalign), 64'd0);
        chk("rst_instret", sif.instret, 64'd0);
        chk("rst_pc_out", sif.pc_out, 64'd0);

        // S_RESET cycle: no request yet
        reset = 1'b0;
        #1;
        chk("s_reset_req", 64'(sif.imem_req), 64'd0);
        chk("s_reset_we", 64'(sif.pc_we), 64'd0);
        step();

        // sequential: 0 -> 4 -> 8 -> C
        do_fetch(64'h0);
        do_exec(0, 0, 0, 0, 0, 0, 64'h4, 0);
        sif.pc_in = 64'h4;
        do_fetch(64'h4);
        do_exec(0, 0, 0, 0, 0, 0, 64'h8, 0);
        sif.pc_in = 64'h8;
        do_fetch(64'h8);
        do_exec(0, 0, 0, 0, 0, 0, 64'hC, 0);
        sif.pc_in = 64'hC;
        chk("instret_seq", sif.instret, 64'd3);

        // priority: jump beats branch
        do_fetch(64'hC);
        do_exec(1, 64'h200, 1, 64'h100, 0, 0, 64'h100, 0);
        sif.pc_in = 64'h100;
        chk("instret_jump", sif.instret, 64'd4);

        // priority: trap beats jump/branch/exec_done, no retire
        do_fetch(64'h100);
        do_exec(1, 64'h200, 1, 64'h100, 1, 64'h80, 64'h80, 0);
        sif.pc_in = 64'h80;
        chk("instret_trap", sif.instret, 64'd4);

        do_fetch(64'h80);
        do_exec(0, 0, 0, 0, 0, 0, 64'h84, 0);
        sif.pc_in = 64'h84;
        chk("instret_after_84", sif.instret, 64'd5);

        // trap pulse during a fetch stalled for 3 cycles
        sif.imem_ready  = 1'b0;
        sif.trap        = 1'b1;
        sif.trap_vector = 64'h80;
        #1;
        chk("tf_req0", 64'(sif.imem_req), 64'd1);
        chk("tf_addr0", sif.imem_addr, 64'h84);
        chk("tf_iv0", 64'(sif.instr_valid), 64'd0);
        chk("tf_we0", 64'(sif.pc_we), 64'd0);
        step();
        sif.trap        = 1'b0;
        sif.trap_vector = 64'h3C0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("tf_req_hold", 64'(sif.imem_req), 64'd1);
            chk("tf_addr_hold", sif.imem_addr, 64'h84);
            chk("tf_we_hold", 64'(sif.pc_we), 64'd0);
            step();
        end
        sif.imem_ready = 1'b1;
        #1;
        chk("tf_ready_iv", 64'(sif.instr_valid), 64'd0);
        chk("tf_ready_we", 64'(sif.pc_we), 64'd1);
        chk("tf_ready_pc_out", sif.pc_out, 64'h80);
        step();
        sif.imem_ready = 1'b0;
        sif.pc_in      = 64'h80;
        chk("tf_instret", sif.instret, 64'd5);
        do_fetch(64'h80);

        // misaligned branch: redirect to aligned trap vector, no retire
        do_exec(1, 64'h102, 0, 0, 0, 64'h83, 64'h80, 1);
        sif.pc_in = 64'h80;
        chk("instret_misalign", sif.instret, 64'd5);

        // wrap at top of address space
        sif.pc_in = 64'hFFFF_FFFF_FFFF_FFFC;
        do_fetch(64'hFFFF_FFFF_FFFF_FFFC);
        do_exec(0, 0, 0, 0, 0, 0, 64'h0, 0);
        sif.pc_in = 64'h0;
        chk("instret_wrap", sif.instret, 64'd6);

        // reset in the middle of a fetch
        sif.pc_in = 64'h40;
        #1;
        chk("rm_req_before", 64'(sif.imem_req), 64'd1);
        reset = 1'b1;
        #1;
        chk("rm_req", 64'(sif.imem_req), 64'd0);
        chk("rm_addr", sif.imem_addr, 64'd0);
        chk("rm_instret", sif.instret, 64'd0);
        chk("rm_we", 64'(sif.pc_we), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rm_s_reset_req", 64'(sif.imem_req), 64'd0);
        chk("rm_instret_after", sif.instret, 64'd0);
        step();
        chk("rm_refetch_req", 64'(sif.imem_req), 64'd1);
        chk("rm_refetch_addr", sif.imem_addr, 64'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/advance controller for the 64-bit program counter register. It drives the PC register's write port and data input. It runs the instruction-memory fetch handshake and holds each fetched instruction while the core executes it. It then picks the next PC by priority: trap > jump > branch > sequential. It also keeps a retired-instruction count and flags misaligned control-transfer targets.

## Interface
- XLEN, 64, PC/address width
- INSTR_BYTES, 4, sequential increment; targets must be INSTR_BYTES-aligned
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- pc_in  in  XLEN  current PC, the PC register output
- pc_out  out  XLEN  next-PC value, wired to the PC register data input
- pc_we  out  1  PC register write enable; one-cycle pulse
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address
- imem_ready  in  1  fetch complete; instruction data valid this cycle
- instr_valid  out  1  one-cycle pulse: fetched instruction handed to the core
- exec_done  in  1  core finished the current instruction
- branch_taken / branch_target  in  1 / XLEN  conditional redirect, sampled with exec_done
- jump / jump_target  in  1 / XLEN  unconditional redirect, sampled with exec_done
- trap / trap_vector  in  1 / XLEN  asynchronous-to-flow trap request; trap_vector[1:0] treated as 00
- misalign  out  1  one-cycle pulse: selected branch/jump target misaligned
- instret  out  64  retired-instruction counter

## Operation
- States: S_RESET, S_FETCH, S_EXEC.
- **S_RESET:** no requests. Goes to S_FETCH on the first cycle with reset=0. Any trap is ignored.
- **S_FETCH:**
  - imem_req=1 and imem_addr=pc_in. Both are held stable until imem_ready.
  - On imem_ready with no trap pending: pulse instr_valid, go to S_EXEC.
- **Trap during S_FETCH:**
  - trap seen in S_FETCH (including the imem_ready cycle) sets trap_pend and latches trap_vector.
  - The handshake still completes.
  - On imem_ready: no instr_valid, pc_we=1, pc_out=latched vector, clear trap_pend, stay in S_FETCH.
- **S_EXEC:** waits for exec_done or trap.
  - On trap: pc_we=1, pc_out=trap_vector, go to S_FETCH, instret unchanged. The trap overrides a simultaneous exec_done.
  - On exec_done without trap, the target is chosen as jump_target, else branch_target when branch_taken, else pc_in+INSTR_BYTES.
  - Aligned target: pc_we=1, pc_out=target, instret+1, go to S_FETCH.
  - Misaligned jump/branch target (low log2(INSTR_BYTES) bits ≠ 0): misalign=1, pc_out=trap_vector, pc_we=1, instret unchanged.
- Sequential add wraps modulo 2^XLEN (FFFF_FFFF_FFFF_FFFC → 0). instret wraps likewise.
- **Reset mid-operation:**
  - pc_we, imem_req and instr_valid are gated to 0 combinationally while reset=1.
  - Any outstanding fetch is abandoned.
  - trap_pend is cleared.
- **Output values in reset and in the S_RESET cycle:** pc_we=0, imem_req=0, imem_addr=0, instr_valid=0, misalign=0, instret=0, pc_out=0.
- pc_out is 0 whenever pc_we=0.

## Timing
- **Output paths:**
  - pc_we, pc_out, instr_valid and misalign are combinational from state and same-cycle inputs.
  - The PC register captures pc_out at the end of the pc_we cycle.
  - pc_in shows the new value the following cycle.
- exec_done → next imem_req: 1 cycle, with imem_addr equal to the new PC.
- imem_ready → instr_valid: 0 cycles (same cycle). The next exec_done may come no earlier than the following cycle.
- Minimum instruction period: 2 cycles (single-cycle fetch plus single-cycle exec).
- imem_req never deasserts before imem_ready, except under reset.
- Exactly one pc_we per instruction or per trap; never two in consecutive cycles without an intervening fetch.
- Redirect inputs are ignored outside S_EXEC.

## Structure
- **Shared package pc_seq_pkg:**
  - state enum S_RESET/S_FETCH/S_EXEC
  - next-PC source enum NPC_SEQ/NPC_BRANCH/NPC_JUMP/NPC_TRAP
  - XLEN and INSTR_BYTES defaults
- **Sub-module pc_next_sel (combinational):**
  - priority mux plus alignment check
  - outputs the selected target, its source enum and the misalign flag
- The FSM, trap_pend/vector latch and instret counter stay in pc_sequencer.

## Test plan
- **Reset then sequential:** reset 2 cycles, pc_in=0. imem_ready 1 cycle after the request, exec_done 1 cycle after instr_valid → pc_out 4, 8, 0xC; instret=3 after three instructions.
- **Priority:** at exec_done, jump=1 (0x100) with branch_taken=1 (0x200) → pc_out=0x100. Same with trap=1 (trap_vector=0x80) → pc_out=0x80, instret unchanged.
- **Trap during fetch:** trap pulses while imem_ready is held low 3 cycles → no instr_valid. pc_we with 0x80 on the ready cycle; next imem_addr=0x80.
- **Misalign:** branch_taken with target 0x102 → misalign=1, pc_out=trap_vector, instret unchanged.
- **Wrap:** pc_in=0xFFFF_FFFF_FFFF_FFFC sequential → pc_out=0.
- **Reset mid-fetch:** reset asserted while imem_req=1 → imem_req=0 that cycle, instret=0. A new fetch to pc_in starts one cycle after reset deasserts.
